// File: rtl/sccb_pkg.sv
// sccb_pkg: definitions shared by the SCCB target and the SCCB master.
//   sccb_state_e : protocol FSM states
//   SCCB_WR_BIT  : R/W bit value of a write ID byte
//   SCCB_RD_BIT  : R/W bit value of a read ID byte
//   shift_in()   : MSB-first bit shifter
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ID        = 4'd1,
    ID_ACK    = 4'd2,
    SUB       = 4'd3,
    SUB_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RD_NA     = 4'd8,
    WAIT_STOP = 4'd9
  } sccb_state_e;

  localparam logic SCCB_WR_BIT = 1'b0;
  localparam logic SCCB_RD_BIT = 1'b1;

  // Shift one serial bit into the LSB. The first bit received ends up as the MSB.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
    return {cur[6:0], b};
  endfunction

endpackage

// File: rtl/sccb_target_if.sv
// sccb_target_if: SCCB pad-side signals.
//   sio_c     : SCCB clock from the master
//   sio_d_in  : resolved level of the sio_d pad
//   sio_d_out : level the target drives when sio_d_oe=1
//   sio_d_oe  : target tristate enable for sio_d
interface sccb_target_if;
  logic sio_c;
  logic sio_d_in;
  logic sio_d_out;
  logic sio_d_oe;

  modport master (output sio_c, output sio_d_in, input sio_d_out, input sio_d_oe);
  modport slave  (input sio_c, input sio_d_in, output sio_d_out, output sio_d_oe);
endinterface

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: synchronizes sio_c/sio_d into the xclk domain.
// Then it detects edges and bus conditions on the synchronized lines.
//   xclk, rst      : clock, asynchronous active-high reset
//   sio_c, sio_d   : raw pad inputs
//   sc, sd         : synchronized levels
//   sc_rise/fall   : single-cycle edge strobes of sc
//   start / stop   : sd falling / rising while sc stays high
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic xclk,
  input  logic rst,
  input  logic sio_c,
  input  logic sio_d,
  output logic sc,
  output logic sd,
  output logic sc_rise,
  output logic sc_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] sc_pipe_r;
  logic [SYNC_STAGES-1:0] sd_pipe_r;
  logic                   sc_prev_r;
  logic                   sd_prev_r;

  // The synchronizer chain is followed by one edge-detect stage.
  // It resets to the idle-bus level (both lines high), so reset release causes no spurious edge.
  always_ff @(posedge xclk or posedge rst) begin
    if (rst) begin
      sc_pipe_r <= {SYNC_STAGES{1'b1}};
      sd_pipe_r <= {SYNC_STAGES{1'b1}};
      sc_prev_r <= 1'b1;
      sd_prev_r <= 1'b1;
    end else begin
      sc_pipe_r <= {sc_pipe_r[SYNC_STAGES-2:0], sio_c};
      sd_pipe_r <= {sd_pipe_r[SYNC_STAGES-2:0], sio_d};
      sc_prev_r <= sc_pipe_r[SYNC_STAGES-1];
      sd_prev_r <= sd_pipe_r[SYNC_STAGES-1];
    end
  end

  assign sc      = sc_pipe_r[SYNC_STAGES-1];
  assign sd      = sd_pipe_r[SYNC_STAGES-1];
  assign sc_rise = sc & ~sc_prev_r;
  assign sc_fall = ~sc & sc_prev_r;
  // sc must be high on both samples, so an sd change next to an sc edge is not a condition.
  assign start   = sc & sc_prev_r & sd_prev_r & ~sd;
  assign stop    = sc & sc_prev_r & ~sd_prev_r & sd;

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB camera-side responder.
// It decodes 3-phase writes (ID, sub-address, data) and 2-phase reads (ID|R, data).
//   xclk, rst        : system clock, asynchronous active-high reset
//   bus (slave)      : sio_c / sio_d_in / sio_d_out / sio_d_oe pad signals
//   wr_valid         : one-cycle pulse when a write completes
//   wr_addr/wr_data  : sub-address and data of that write
//   rd_addr          : last received sub-address, held for the register file
//   rd_data          : register-file data for rd_addr, loaded at the start of a read byte
//   busy             : high from START until STOP or abort
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ID      = 7'h21,
  parameter int         SYNC_STAGES = 2,
  parameter bit         ACK_EN      = 1'b1
) (
  input  logic              xclk,
  input  logic              rst,
  sccb_target_if.slave      bus,
  output logic              wr_valid,
  output logic [7:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  logic sc_s, sd_s, sc_rise_s, sc_fall_s, start_s, stop_s;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .xclk    (xclk),
    .rst     (rst),
    .sio_c   (bus.sio_c),
    .sio_d   (bus.sio_d_in),
    .sc      (sc_s),
    .sd      (sd_s),
    .sc_rise (sc_rise_s),
    .sc_fall (sc_fall_s),
    .start   (start_s),
    .stop    (stop_s)
  );

  sccb_state_e state_r, state_nx;
  logic [2:0]  cnt_r, cnt_nx;
  logic [7:0]  shift_r, shift_nx, byte_s;
  logic        rw_r, rw_nx;
  logic        ninth_r, ninth_nx;   // 9th/last rise seen; the next fall ends the phase
  logic        oe_r, oe_nx, out_r, out_nx;
  logic [7:0]  sub_r, sub_nx, rd_addr_r, rd_addr_nx;
  logic [7:0]  wr_addr_r, wr_addr_nx, wr_data_r, wr_data_nx;
  logic        wr_valid_r, wr_valid_nx, busy_r;
  logic        oe_allow_s;

  // Compute the next state and all datapath/output register values.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    shift_nx    = shift_r;
    rw_nx       = rw_r;
    ninth_nx    = ninth_r;
    oe_nx       = oe_r;
    out_nx      = out_r;
    sub_nx      = sub_r;
    rd_addr_nx  = rd_addr_r;
    wr_addr_nx  = wr_addr_r;
    wr_data_nx  = wr_data_r;
    wr_valid_nx = 1'b0;
    byte_s      = shift_in(shift_r, sd_s);

    if (stop_s) begin
      state_nx = IDLE;
      cnt_nx   = 3'd0;
      ninth_nx = 1'b0;
      oe_nx    = 1'b0;
      out_nx   = 1'b0;
    end else if (start_s) begin
      // A repeated START also lands here and abandons any partial byte.
      state_nx = ID;
      cnt_nx   = 3'd0;
      ninth_nx = 1'b0;
      shift_nx = 8'h00;
      oe_nx    = 1'b0;
      out_nx   = 1'b0;
    end else begin
      case (state_r)
        ID, SUB, WDATA: begin
          if (sc_rise_s) begin
            shift_nx = byte_s;
            cnt_nx   = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              case (state_r)
                ID: begin
                  rw_nx    = byte_s[0];
                  state_nx = (byte_s[7:1] == DEV_ID) ? ID_ACK : WAIT_STOP;
                end
                SUB: begin
                  sub_nx     = byte_s;
                  rd_addr_nx = byte_s;
                  state_nx   = SUB_ACK;
                end
                default: state_nx = WDATA_ACK;
              endcase
            end else begin
              state_nx = state_r;
            end
          end else begin
            state_nx = state_r;
          end
        end

        ID_ACK, SUB_ACK, WDATA_ACK: begin
          if (sc_rise_s) begin
            ninth_nx = 1'b1;
          end else if (sc_fall_s) begin
            if (ninth_r) begin
              ninth_nx = 1'b0;
              oe_nx    = 1'b0;
              out_nx   = 1'b0;
              cnt_nx   = 3'd0;
              case (state_r)
                ID_ACK: begin
                  if (rw_r == SCCB_RD_BIT) begin
                    // Read data is sampled once, here, and its MSB driven immediately.
                    shift_nx = rd_data;
                    out_nx   = rd_data[7];
                    oe_nx    = 1'b1;
                    state_nx = RDATA;
                  end else begin
                    state_nx = SUB;
                  end
                end
                SUB_ACK: state_nx = WDATA;
                default: begin
                  wr_valid_nx = 1'b1;
                  wr_addr_nx  = sub_r;
                  wr_data_nx  = shift_r;
                  state_nx    = WAIT_STOP;
                end
              endcase
            end else begin
              // Fall after the 8th rise: start the ACK window.
              oe_nx  = ACK_EN;
              out_nx = 1'b0;
            end
          end else begin
            ninth_nx = ninth_r;
          end
        end

        RDATA: begin
          if (sc_rise_s) begin
            cnt_nx = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              ninth_nx = 1'b1;
            end else begin
              ninth_nx = ninth_r;
            end
          end else if (sc_fall_s) begin
            if (ninth_r) begin
              ninth_nx = 1'b0;
              oe_nx    = 1'b0;
              out_nx   = 1'b0;
              state_nx = RD_NA;
            end else begin
              shift_nx = {shift_r[6:0], 1'b0};
              out_nx   = shift_r[6];
            end
          end else begin
            ninth_nx = ninth_r;
          end
        end

        RD_NA: begin
          // The master's NA bit is a don't-care; its clock pulse only closes the byte.
          if (sc_rise_s) begin
            state_nx = WAIT_STOP;
          end else begin
            state_nx = RD_NA;
          end
        end

        IDLE, WAIT_STOP: begin
          oe_nx  = 1'b0;
          out_nx = 1'b0;
        end

        default: begin
          state_nx = IDLE;
          oe_nx    = 1'b0;
          out_nx   = 1'b0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge xclk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge xclk or posedge rst) begin
    if (rst) begin
      cnt_r      <= 3'd0;
      shift_r    <= 8'h00;
      rw_r       <= 1'b0;
      ninth_r    <= 1'b0;
      oe_r       <= 1'b0;
      out_r      <= 1'b0;
      sub_r      <= 8'h00;
      rd_addr_r  <= 8'h00;
      wr_addr_r  <= 8'h00;
      wr_data_r  <= 8'h00;
      wr_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_nx;
      shift_r    <= shift_nx;
      rw_r       <= rw_nx;
      ninth_r    <= ninth_nx;
      oe_r       <= oe_nx;
      out_r      <= out_nx;
      sub_r      <= sub_nx;
      rd_addr_r  <= rd_addr_nx;
      wr_addr_r  <= wr_addr_nx;
      wr_data_r  <= wr_data_nx;
      wr_valid_r <= wr_valid_nx;
      busy_r     <= (state_nx != IDLE);
    end
  end

  // While sc is high, only the read-data or ACK phases may drive the line.
  // Otherwise the target could collide with a master START/STOP.
  assign oe_allow_s = ~sc_s || (state_r == RDATA) || (state_r == ID_ACK) ||
                      (state_r == SUB_ACK) || (state_r == WDATA_ACK);

  assign bus.sio_d_oe  = oe_r & oe_allow_s;
  assign bus.sio_d_out = out_r;
  assign wr_valid      = wr_valid_r;
  assign wr_addr       = wr_addr_r;
  assign wr_data       = wr_data_r;
  assign rd_addr       = rd_addr_r;
  assign busy          = busy_r;

endmodule
